pipeline_stage_elastic: RTL and testbench
=========================================

Name: pipeline_stage_elastic

Overview:
- Parametrised successor to the fixed per-stage pipeline registers.
- Provides one generic inter-stage register slice with a valid/ready handshake and a 2-entry skid buffer, so back-pressure is registered rather than a global Busy fan-out.
- Flush drops in-flight beats. Placed between any two core pipeline stages (e.g. E->M); payload is an opaque bus packed by the instantiating stage.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- CLEAR_ON_FLUSH, 1, when 1 the out_data register is zeroed on flush or reset; when 0 it holds a stale value and only the valids clear.
- CNT_WIDTH, 16, width of the perf counters (used only with PIPE_STAGE_PERF_EN).

Ports:
- CLK  input  1  clock, rising edge.
- RESETn  input  1  asynchronous active-low reset.
- FLUSH  input  1  synchronous flush; discards all held beats.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept; a registered signal only.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  downstream beat present; registered.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  downstream payload; registered.
- stall_cnt  output  CNT_WIDTH  perf counter; present only with PIPE_STAGE_PERF_EN.
- bubble_cnt  output  CNT_WIDTH  perf counter; present only with PIPE_STAGE_PERF_EN.

Behaviour:
- Storage: main entry (out_valid, out_data) plus skid entry (skid_valid, skid_data).
- Handshake:
  - in_ready = ~skid_valid.
  - Upstream transfer = in_valid & in_ready.
  - Downstream transfer = out_valid & out_ready.
- Reset (RESETn=0, async): out_valid=0, skid_valid=0, in_ready=1, out_data=0, skid_data=0, counters=0.
- Latency: an accepted beat appears on out_data the next cycle when the main entry is empty or is draining that same cycle. Full throughput is 1 beat/cycle.
- States, encoded by {skid_valid, out_valid}:
  - EMPTY(00):
    - accept -> ONE, beat loaded into main.
  - ONE(01):
    - accept & drain -> ONE, main reloaded.
    - accept & ~drain -> FULL, beat goes to skid.
    - ~accept & drain -> EMPTY.
    - otherwise hold.
  - FULL(11): in_ready=0, no accept.
    - drain -> ONE; skid moves to main, skid_valid=0.
    - otherwise hold.
  - 10 is unreachable.
- Ordering: strict FIFO; the skid beat always precedes any newer beat.
- Data registers load only on transfer. out_data is stable while out_valid & ~out_ready (AXI-style hold rule).
- Upstream must hold in_data/in_valid while in_valid & ~in_ready. The block does not check this.
- FLUSH=1 at a clock edge:
  - Next state EMPTY regardless of in_valid, out_ready, or an accept in the same cycle; the accepted beat is discarded.
  - The downstream transfer in the flush cycle still counts as completed for the consumer.
  - If CLEAR_ON_FLUSH=1, out_data and skid_data are zeroed.
- in_ready never depends combinationally on FLUSH or out_ready.
- Reset mid-operation: immediate return to the reset values; no beat is preserved.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & ~out_ready.
  - bubble_cnt increments each cycle with ~out_valid.
  - Both counters saturate at 2^CNT_WIDTH-1 (no wrap).
  - Reset clears both; FLUSH does not clear them.
- Undefined: stall_cnt/bubble_cnt ports and all their logic are absent; the handshake behaviour is identical.

Test Plan:
- Reset: drive RESETn=0 asynchronously mid-cycle -> out_valid=0, in_ready=1, out_data=0 immediately; with the feature, counters=0.
- Streaming: out_ready=1, send 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later, back-to-back; in_ready stays 1.
- Back-pressure: main holds 0xA1, out_ready=0, send 0xB2 -> skid fills, in_ready=0 next cycle. Then out_ready=1 -> 0xA1 then 0xB2 in order, in_ready=1 again.
- Flush when FULL: main=0xA1, skid=0xB2, FLUSH=1 with in_valid=1 (0xC3) -> next cycle out_valid=0, in_ready=1, out_data=0 (CLEAR_ON_FLUSH=1); 0xC3 never appears.
- Flush with CLEAR_ON_FLUSH=0: same stimulus -> out_valid=0 and out_data retains 0xA1.
- Perf (PIPE_STAGE_PERF_EN, CNT_WIDTH=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15; 3 idle cycles after reset -> bubble_cnt=3.

Source files
------------

// File: rtl/pipeline_stage_elastic.sv
// Elastic inter-stage register slice: valid/ready handshake with a 2-entry skid buffer.
// Optional perf counters (stall_cnt/bubble_cnt) enabled by defining PIPE_STAGE_PERF_EN.
module pipeline_stage_elastic #(
    parameter int unsigned WIDTH          = 32,
    parameter bit          CLEAR_ON_FLUSH = 1'b1,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 FLUSH,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] bubble_cnt
`endif
);

    // State encoding is {skid_valid, out_valid}; 2'b10 cannot be reached.
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b01;
    localparam logic [1:0] FULL  = 2'b11;

    if (WIDTH == 0) begin : g_width_chk
        $error("pipeline_stage_elastic: WIDTH must be >= 1");
    end
    if (CNT_WIDTH == 0) begin : g_cnt_width_chk
        $error("pipeline_stage_elastic: CNT_WIDTH must be >= 1");
    end

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             in_ready_q;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] skid_data_q;

    logic accept_c;
    logic drain_c;
    logic load_main_in_c;
    logic load_main_skid_c;
    logic load_skid_c;
    logic clear_data_c;

    assign accept_c = in_valid & in_ready_q;
    assign drain_c  = state_q[0] & out_ready;

    // State register; in_ready is registered from the next skid occupancy.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= ~state_d[1];
        end
    end

    // Next-state and data-path load selects.
    always_comb begin
        state_d          = state_q;
        load_main_in_c   = 1'b0;
        load_main_skid_c = 1'b0;
        load_skid_c      = 1'b0;
        clear_data_c     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept_c) begin
                    state_d        = ONE;
                    load_main_in_c = 1'b1;
                end
            end
            ONE: begin
                if (accept_c && drain_c) begin
                    load_main_in_c = 1'b1;
                end else if (accept_c) begin
                    state_d     = FULL;
                    load_skid_c = 1'b1;
                end else if (drain_c) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain_c) begin
                    state_d          = ONE;
                    load_main_skid_c = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush overrides everything, including a same-cycle accept.
        if (FLUSH) begin
            state_d          = EMPTY;
            load_main_in_c   = 1'b0;
            load_main_skid_c = 1'b0;
            load_skid_c      = 1'b0;
            clear_data_c     = CLEAR_ON_FLUSH;
        end
    end

    // Main data register: loads only on transfer, so it holds under back-pressure.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            out_data_q <= '0;
        end else if (clear_data_c) begin
            out_data_q <= '0;
        end else if (load_main_in_c) begin
            out_data_q <= in_data;
        end else if (load_main_skid_c) begin
            out_data_q <= skid_data_q;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            skid_data_q <= '0;
        end else if (clear_data_c) begin
            skid_data_q <= '0;
        end else if (load_skid_c) begin
            skid_data_q <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = state_q[0];
    assign out_data  = out_data_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] bubble_cnt_q;

    // Saturating perf counters; FLUSH intentionally leaves them alone.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (state_q[0] && !out_ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            end
            if (!state_q[0] && (bubble_cnt_q != '1)) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// Bench for pipeline_stage_elastic: directed plan steps plus random traffic against a queue model.
// Two instances share stimulus: CLEAR_ON_FLUSH=1 (a) and CLEAR_ON_FLUSH=0 (b).
module tb_pipeline_stage_elastic;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          CLK;
    logic          RESETn;
    logic          FLUSH;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          out_ready;
    logic          in_ready_a, out_valid_a;
    logic [W-1:0]  out_data_a;
    logic          in_ready_b, out_valid_b;
    logic [W-1:0]  out_data_b;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall_a, bubble_a, stall_b, bubble_b;
`endif

    pipeline_stage_elastic #(.WIDTH(W), .CLEAR_ON_FLUSH(1'b1), .CNT_WIDTH(CW)) dut_a (
        .CLK(CLK), .RESETn(RESETn), .FLUSH(FLUSH),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_a), .bubble_cnt(bubble_a)
`endif
    );

    pipeline_stage_elastic #(.WIDTH(W), .CLEAR_ON_FLUSH(1'b0), .CNT_WIDTH(CW)) dut_b (
        .CLK(CLK), .RESETn(RESETn), .FLUSH(FLUSH),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_b), .bubble_cnt(bubble_b)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: pending beats in FIFO order, plus last visible payload per variant.
    logic [W-1:0] mq[$];
    logic [W-1:0] last_a;
    logic [W-1:0] last_b;
    int           stall_m;
    int           bubble_m;
    int           checks;
    int           passed;
    logic         blocked;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":out_valid_a"}, 32'(out_valid_a), 32'(mq.size() != 0));
        chk({tag, ":out_valid_b"}, 32'(out_valid_b), 32'(mq.size() != 0));
        chk({tag, ":in_ready_a"},  32'(in_ready_a),  32'(mq.size() < 2));
        chk({tag, ":in_ready_b"},  32'(in_ready_b),  32'(mq.size() < 2));
        chk({tag, ":out_data_a"},  32'(out_data_a),  32'(last_a));
        chk({tag, ":out_data_b"},  32'(out_data_b),  32'(last_b));
`ifdef PIPE_STAGE_PERF_EN
        chk({tag, ":stall_a"},  32'(stall_a),  32'(stall_m));
        chk({tag, ":bubble_a"}, 32'(bubble_a), 32'(bubble_m));
        chk({tag, ":stall_b"},  32'(stall_b),  32'(stall_m));
        chk({tag, ":bubble_b"}, 32'(bubble_b), 32'(bubble_m));
`endif
    endtask

    // Apply one cycle of inputs (called at posedge+1), advance the model, check at next posedge+1.
    task automatic cycle(input string tag, input logic iv, input logic [W-1:0] id,
                         input logic ordy, input logic fl);
        bit acc;
        bit drn;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        FLUSH     = fl;
        acc = iv && (mq.size() < 2);
        drn = (mq.size() != 0) && ordy;
        blocked = iv && !(mq.size() < 2);
        if (mq.size() != 0 && !ordy && stall_m < CNT_MAX) stall_m++;
        if (mq.size() == 0 && bubble_m < CNT_MAX) bubble_m++;
        if (drn) void'(mq.pop_front());
        if (acc) mq.push_back(id);
        if (fl) mq.delete();
        if (mq.size() != 0) begin
            last_a = mq[0];
            last_b = mq[0];
        end else if (fl) begin
            last_a = '0;
        end
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset asserted mid-cycle; checked before the next clock edge.
    task automatic do_reset(input string tag);
        #3;
        RESETn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        FLUSH     = 1'b0;
        mq.delete();
        last_a   = '0;
        last_b   = '0;
        stall_m  = 0;
        bubble_m = 0;
        #1;
        check_all(tag);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RESETn = 1'b1;
    endtask

    initial begin
        logic          iv;
        logic [W-1:0]  id;
        checks  = 0;
        passed  = 0;
        blocked = 1'b0;
        iv      = 1'b0;
        id      = '0;
        RESETn  = 1'b1;
        @(posedge CLK);
        #1;
        do_reset("reset0");

        for (int i = 0; i < 3; i++) cycle("idle", 1'b0, '0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
        chk("bubble_after_3_idle", 32'(bubble_a), 32'd3);
`endif

        // Streaming at full rate.
        cycle("stream1", 1'b1, 16'h0011, 1'b1, 1'b0);
        chk("stream_first", 32'(out_data_a), 32'h11);
        cycle("stream2", 1'b1, 16'h0022, 1'b1, 1'b0);
        chk("stream_second", 32'(out_data_a), 32'h22);
        cycle("stream3", 1'b1, 16'h0033, 1'b1, 1'b0);
        chk("stream_third", 32'(out_data_a), 32'h33);
        chk("stream_ready", 32'(in_ready_a), 32'd1);
        cycle("stream_drain", 1'b0, '0, 1'b1, 1'b0);

        // Back-pressure fills the skid, then drains in order.
        cycle("bp_a1", 1'b1, 16'h00A1, 1'b0, 1'b0);
        cycle("bp_b2", 1'b1, 16'h00B2, 1'b0, 1'b0);
        chk("bp_full_ready", 32'(in_ready_a), 32'd0);
        chk("bp_head_a1", 32'(out_data_a), 32'hA1);
        cycle("bp_drain1", 1'b0, '0, 1'b1, 1'b0);
        chk("bp_head_b2", 32'(out_data_a), 32'hB2);
        chk("bp_ready_back", 32'(in_ready_a), 32'd1);
        cycle("bp_drain2", 1'b0, '0, 1'b1, 1'b0);

        // Flush while FULL with a concurrent upstream beat.
        cycle("fl_a1", 1'b1, 16'h00A1, 1'b0, 1'b0);
        cycle("fl_b2", 1'b1, 16'h00B2, 1'b0, 1'b0);
        cycle("fl_c3", 1'b1, 16'h00C3, 1'b0, 1'b1);
        chk("flush_valid", 32'(out_valid_a), 32'd0);
        chk("flush_clear_data", 32'(out_data_a), 32'h0);
        chk("flush_keep_data", 32'(out_data_b), 32'hA1);
        cycle("fl_after1", 1'b0, '0, 1'b1, 1'b0);
        cycle("fl_after2", 1'b0, '0, 1'b1, 1'b0);

        // Long stall drives the stall counter into saturation.
        cycle("stall_load", 1'b1, 16'h0055, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle("stall", 1'b0, '0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_saturated", 32'(stall_a), 32'(CNT_MAX));
`endif
        cycle("stall_drain", 1'b0, '0, 1'b1, 1'b0);

        // Random traffic honouring the upstream hold rule.
        for (int i = 0; i < 400; i++) begin
            if (!blocked) begin
                iv = ($urandom_range(0, 3) != 0);
                id = W'($urandom);
            end
            cycle("rand", iv, id, ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0));
        end

        do_reset("reset_mid");
        cycle("post_reset", 1'b1, 16'h1234, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
